vec_wb_arbiter: RTL and testbench
=================================

VEC_WB_ARBITER -- requirements
Module: vec_wb_arbiter

Interface
REQ-001 The module SHALL have parameter ELEN, default 32, meaning bits per vector element.
REQ-002 The module SHALL have parameter VLEN, default 64, meaning elements per vector register.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have ports a_valid (input, 1) and a_ready (output, 1): requester A writeback handshake.
REQ-006 The module SHALL have ports a_addr (input, 5) and a_data (input, ELEN x [0:VLEN-1] unpacked): requester A destination register and vector.
REQ-007 The module SHALL have ports b_valid, b_ready, b_addr and b_data with the same widths and meaning as the A ports, for requester B.
REQ-008 The module SHALL have ports iss_valid (input, 1), iss_addr (input, 5) and iss_ready (output, 1): issue-stage reservation of a destination register.
REQ-009 The module SHALL have inputs rd_addr1 and rd_addr2 (5 each) and outputs rd_busy1 and rd_busy2 (1 each): source hazard query.
REQ-010 The module SHALL have outputs wrten (1), addr3 (5) and v3dat (ELEN x [0:VLEN-1]): the vector register file write port.
REQ-011 The module SHALL have output pend (32): the pending-write bitmap, where bit n set means vector register n is reserved.

Function
REQ-012 The module SHALL grant at most one requester per cycle; readiness SHALL be combinational (x_ready=1 only for the granted requester), and a transfer occurs when x_valid && x_ready.
REQ-013 With a single valid requester, that requester SHALL be granted.
REQ-014 With both A and B valid, the module SHALL grant the requester not recorded in last_grant; last_grant SHALL update only on a transfer.
REQ-015 A transfer at edge N SHALL register wrten=1, addr3 and v3dat for the cycle after edge N, giving a latency of 1.
REQ-016 With no transfer, wrten SHALL be 0; addr3 and v3dat SHALL hold their previous values.
REQ-017 iss_ready SHALL equal ~pend[iss_addr], which blocks a WAW reservation.
REQ-018 iss_valid && iss_ready SHALL set pend[iss_addr] at the next edge.
REQ-019 wrten=1 SHALL clear pend[addr3] at the same edge the register file commits the write.
REQ-020 When a set and a clear target the same address in the same cycle, the set SHALL win.
REQ-021 A write to a non-pending address SHALL be performed normally, and the clear SHALL have no effect on pend.
REQ-022 Without the forwarding feature, rd_busyN SHALL equal pend[rd_addrN], combinationally.
REQ-023 Register 0 SHALL have no special treatment.
REQ-024 Requester data SHALL be sampled only on the transfer edge; requesters SHALL hold valid, addr and data stable until ready.

Reset
REQ-025 While rst=1, asynchronously, the module SHALL force pend=0, wrten=0, addr3=0, v3dat all elements 0, and last_grant=B, so that A wins the first tie.
REQ-026 Reset asserted mid-operation SHALL discard a registered but uncommitted write (wrten forced 0) and all reservations.
REQ-027 In the first cycle after reset release, a_ready and b_ready SHALL follow REQ-012 to REQ-014, and iss_ready SHALL be 1.

Configuration
REQ-028 When macro VECWB_FWD_EN is defined, the module SHALL add outputs fwd_sel1 and fwd_sel2 (1 bit each).
REQ-029 With VECWB_FWD_EN defined, fwd_selN SHALL equal wrten && pend[rd_addrN] && (addr3==rd_addrN), and rd_busyN SHALL equal pend[rd_addrN] && ~fwd_selN, so the consumer muxes v3dat for that source.
REQ-030 When VECWB_FWD_EN is undefined, the fwd_sel ports SHALL be absent and REQ-022 SHALL apply.

Verification
REQ-031 Bench SHALL cover: reset, then iss_valid=1, iss_addr=5 -> pend=0x00000020 next cycle; iss_addr=5 again -> iss_ready=0.
REQ-032 Bench SHALL cover: both requesters valid for 4 cycles, a_addr=3 and b_addr=7 -> addr3 sequence 3,7,3,7 with wrten=1 each cycle.
REQ-033 Bench SHALL cover: pend[9]=1, a_valid with a_addr=9 -> rd_busy1 (rd_addr1=9) stays 1 through the wrten cycle, and is 0 the cycle after with pend[9]=0; with VECWB_FWD_EN, fwd_sel1=1 and rd_busy1=0 in the wrten cycle.
REQ-034 Bench SHALL cover: in the wrten cycle for addr3=4, iss_valid with iss_addr=4 after the clear -> pend[4]=1 next cycle (set wins), wrten=1 observed once.
REQ-035 Bench SHALL cover: rst pulsed asynchronously between clock edges while wrten=1 and pend=0xFFFFFFFF -> wrten=0 and pend=0 immediately, with no register file write.
REQ-036 Bench SHALL cover: a_valid held with a_data element 0=0xDEADBEEF and element 63=0x1 -> v3dat matches exactly, and a_data changed after the transfer is not propagated.

Source files
------------

// File: rtl/vec_wb_arbiter.sv
// Two-requester vector writeback arbiter with a pending-write scoreboard for the vector register file.
// Optional result forwarding (fwd_sel1/fwd_sel2) is built when VECWB_FWD_EN is defined.
module vec_wb_arbiter #(
    parameter int ELEN = 32,
    parameter int VLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_addr,
    input  logic [ELEN-1:0] a_data [0:VLEN-1],
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_addr,
    input  logic [ELEN-1:0] b_data [0:VLEN-1],
    input  logic            iss_valid,
    input  logic [4:0]      iss_addr,
    output logic            iss_ready,
    input  logic [4:0]      rd_addr1,
    input  logic [4:0]      rd_addr2,
    output logic            rd_busy1,
    output logic            rd_busy2,
    output logic            wrten,
    output logic [4:0]      addr3,
    output logic [ELEN-1:0] v3dat [0:VLEN-1],
    output logic [31:0]     pend
`ifdef VECWB_FWD_EN
    ,
    output logic            fwd_sel1,
    output logic            fwd_sel2
`endif
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    grant_t      last_grant;
    logic        grant_a;
    logic        grant_b;
    logic [31:0] pend_next;

    // Ties go to whichever requester did not win the last transfer.
    always_comb begin
        grant_a = a_valid && (!b_valid || (last_grant == GRANT_B));
        grant_b = b_valid && (!a_valid || (last_grant == GRANT_A));
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign iss_ready = ~pend[iss_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_B;
        end else if (grant_a) begin
            last_grant <= GRANT_A;
        end else if (grant_b) begin
            last_grant <= GRANT_B;
        end
    end

    // NOTE: the write-data array is reset too, so v3dat never presents X after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrten <= 1'b0;
            addr3 <= '0;
            v3dat <= '{default: '0};
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            wrten <= grant_a || grant_b;
            if (grant_a) begin
                addr3 <= a_addr;
                v3dat <= a_data;
            end else if (grant_b) begin
                addr3 <= b_addr;
                v3dat <= b_data;
            end
        end
    end

    // The set is applied after the clear so a same-address reservation wins.
    always_comb begin
        // NOTE: default first, so no path through this block can infer a latch.
        pend_next = pend;
        if (wrten) begin
            pend_next[addr3] = 1'b0;
        end
        if (iss_valid && iss_ready) begin
            pend_next[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

`ifdef VECWB_FWD_EN
    assign fwd_sel1 = wrten && pend[rd_addr1] && (addr3 == rd_addr1);
    assign fwd_sel2 = wrten && pend[rd_addr2] && (addr3 == rd_addr2);
    assign rd_busy1 = pend[rd_addr1] && !fwd_sel1;
    assign rd_busy2 = pend[rd_addr2] && !fwd_sel2;
`else
    assign rd_busy1 = pend[rd_addr1];
    assign rd_busy2 = pend[rd_addr2];
`endif

endmodule

// File: tb/tb_vec_wb_arbiter.sv
// Directed bench for vec_wb_arbiter: a reference model predicts grants and reservations,
// and a scoreboard queue holds each expected register-file write until the DUT commits it.
module tb_vec_wb_arbiter;

    localparam int ELEN = 32;
    localparam int VLEN = 64;

    logic            clk;
    logic            rst;
    logic            a_valid;
    logic            a_ready;
    logic [4:0]      a_addr;
    logic [ELEN-1:0] a_data [0:VLEN-1];
    logic            b_valid;
    logic            b_ready;
    logic [4:0]      b_addr;
    logic [ELEN-1:0] b_data [0:VLEN-1];
    logic            iss_valid;
    logic [4:0]      iss_addr;
    logic            iss_ready;
    logic [4:0]      rd_addr1;
    logic [4:0]      rd_addr2;
    logic            rd_busy1;
    logic            rd_busy2;
    logic            wrten;
    logic [4:0]      addr3;
    logic [ELEN-1:0] v3dat [0:VLEN-1];
    logic [31:0]     pend;
`ifdef VECWB_FWD_EN
    logic            fwd_sel1;
    logic            fwd_sel2;
`endif

    vec_wb_arbiter #(.ELEN(ELEN), .VLEN(VLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_busy1  (rd_busy1),
        .rd_busy2  (rd_busy2),
        .wrten     (wrten),
        .addr3     (addr3),
        .v3dat     (v3dat),
        .pend      (pend)
`ifdef VECWB_FWD_EN
        ,
        .fwd_sel1  (fwd_sel1),
        .fwd_sel2  (fwd_sel2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model state: last winner (1 = B), registered write, reservation bitmap.
    logic        m_last;
    logic        m_wrten;
    logic [4:0]  m_addr3;
    logic [31:0] m_pend;

    logic [4:0]           addr_q [$];
    logic [ELEN*VLEN-1:0] data_q [$];
    logic [4:0]           seq [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_a(input logic [15:0] tag);
        for (int i = 0; i < VLEN; i++) a_data[i] = {tag, 16'(i)};
    endtask

    task automatic fill_b(input logic [15:0] tag);
        for (int i = 0; i < VLEN; i++) b_data[i] = {tag, 16'(i)};
    endtask

    task automatic model_reset();
        m_last  = 1'b1;
        m_wrten = 1'b0;
        m_addr3 = '0;
        m_pend  = '0;
        addr_q.delete();
        data_q.delete();
    endtask

    // One clock cycle: predict and check handshakes, push the expected write, then
    // check the registered state just after the edge and pop any committed write.
    task automatic step();
        logic                 ga;
        logic                 gb;
        logic                 ok;
        logic [31:0]          pn;
        logic [4:0]           ea;
        logic [ELEN*VLEN-1:0] d;
        logic [ELEN*VLEN-1:0] ed;
        #2;
        ga = a_valid && (!b_valid || m_last);
        gb = b_valid && (!a_valid || !m_last);
        check("a_ready", {63'd0, a_ready}, {63'd0, ga});
        check("b_ready", {63'd0, b_ready}, {63'd0, gb});
        check("iss_ready", {63'd0, iss_ready}, {63'd0, !m_pend[iss_addr]});
        if (ga || gb) begin
            for (int i = 0; i < VLEN; i++) d[i*ELEN +: ELEN] = ga ? a_data[i] : b_data[i];
            addr_q.push_back(ga ? a_addr : b_addr);
            data_q.push_back(d);
        end
        pn = m_pend;
        if (m_wrten) pn[m_addr3] = 1'b0;
        if (iss_valid && !m_pend[iss_addr]) pn[iss_addr] = 1'b1;
        @(posedge clk);
        #1;
        if (ga) m_last = 1'b0;
        else if (gb) m_last = 1'b1;
        m_wrten = ga || gb;
        if (m_wrten) m_addr3 = ga ? a_addr : b_addr;
        m_pend = pn;
        check("wrten", {63'd0, wrten}, {63'd0, m_wrten});
        check("pend", {32'd0, pend}, {32'd0, m_pend});
        if (m_wrten && addr_q.size() > 0) begin
            ea = addr_q.pop_front();
            ed = data_q.pop_front();
            check("addr3", {59'd0, addr3}, {59'd0, ea});
            ok = 1'b1;
            for (int i = 0; i < VLEN; i++) if (v3dat[i] !== ed[i*ELEN +: ELEN]) ok = 1'b0;
            check("v3dat", {63'd0, ok}, 64'd1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        a_valid   = 1'b0;
        a_addr    = '0;
        b_valid   = 1'b0;
        b_addr    = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        rd_addr1  = '0;
        rd_addr2  = '0;
        fill_a(16'hA000);
        fill_b(16'hB000);
        model_reset();

        // Reset state.
        #3;
        check("rst_pend", {32'd0, pend}, 64'd0);
        check("rst_wrten", {63'd0, wrten}, 64'd0);
        check("rst_addr3", {59'd0, addr3}, 64'd0);
        check("rst_v3dat0", {32'd0, v3dat[0]}, 64'd0);
        check("rst_v3dat63", {32'd0, v3dat[VLEN-1]}, 64'd0);
        check("rst_iss_ready", {63'd0, iss_ready}, 64'd1);
        #4;
        rst = 1'b0;

        // Reservation then WAW block on the same register.
        iss_valid = 1'b1;
        iss_addr  = 5'd5;
        step();
        check("iss_pend5", {32'd0, pend}, 64'h0000_0020);
        #2;
        check("iss_waw_block", {63'd0, iss_ready}, 64'd0);
        step();
        iss_valid = 1'b0;

        // Both requesters valid: alternate, A first after reset.
        a_valid = 1'b1;
        a_addr  = 5'd3;
        b_valid = 1'b1;
        b_addr  = 5'd7;
        for (int k = 0; k < 4; k++) begin
            step();
            seq[k] = addr3;
        end
        check("rr_seq0", {59'd0, seq[0]}, 64'd3);
        check("rr_seq1", {59'd0, seq[1]}, 64'd7);
        check("rr_seq2", {59'd0, seq[2]}, 64'd3);
        check("rr_seq3", {59'd0, seq[3]}, 64'd7);
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        check("hold_addr3", {59'd0, addr3}, 64'd7);

        // Hazard on a reserved register through its writeback.
        iss_valid = 1'b1;
        iss_addr  = 5'd9;
        rd_addr1  = 5'd9;
        rd_addr2  = 5'd3;
        step();
        iss_valid = 1'b0;
        check("busy_reserved", {63'd0, rd_busy1}, 64'd1);
        check("busy2_free", {63'd0, rd_busy2}, 64'd0);
        a_valid = 1'b1;
        a_addr  = 5'd9;
        fill_a(16'hA009);
        step();
        a_valid = 1'b0;
        check("wb9_wrten", {63'd0, wrten}, 64'd1);
`ifdef VECWB_FWD_EN
        check("wb9_fwd_sel1", {63'd0, fwd_sel1}, 64'd1);
        check("wb9_busy1", {63'd0, rd_busy1}, 64'd0);
`else
        check("wb9_busy1", {63'd0, rd_busy1}, 64'd1);
`endif
        step();
        check("after_wb9_busy1", {63'd0, rd_busy1}, 64'd0);
        check("after_wb9_pend9", {63'd0, pend[9]}, 64'd0);

        // Same-cycle set and clear on register 4: the set wins.
        a_valid = 1'b1;
        a_addr  = 5'd4;
        fill_a(16'hA004);
        step();
        a_valid   = 1'b0;
        iss_valid = 1'b1;
        iss_addr  = 5'd4;
        check("sc_wrten", {63'd0, wrten}, 64'd1);
        step();
        iss_valid = 1'b0;
        check("sc_pend4", {63'd0, pend[4]}, 64'd1);
        check("sc_wrten_once", {63'd0, wrten}, 64'd0);

        // Fill every reservation, commit a write, then reset between edges.
        iss_valid = 1'b1;
        for (int k = 0; k < 32; k++) begin
            iss_addr = 5'(k);
            step();
        end
        iss_valid = 1'b0;
        a_valid   = 1'b1;
        a_addr    = 5'd0;
        step();
        a_valid = 1'b0;
        check("pre_rst_pend", {32'd0, pend}, 64'hFFFF_FFFF);
        check("pre_rst_wrten", {63'd0, wrten}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_wrten", {63'd0, wrten}, 64'd0);
        check("async_rst_pend", {32'd0, pend}, 64'd0);
        check("async_rst_addr3", {59'd0, addr3}, 64'd0);
        #1;
        rst = 1'b0;
        model_reset();
        step();

        // Data capture on the transfer edge only.
        for (int i = 0; i < VLEN; i++) a_data[i] = '0;
        a_data[0]      = 32'hDEAD_BEEF;
        a_data[VLEN-1] = 32'h0000_0001;
        a_valid = 1'b1;
        a_addr  = 5'd2;
        step();
        a_valid = 1'b0;
        check("data_e0", {32'd0, v3dat[0]}, 64'hDEAD_BEEF);
        check("data_e63", {32'd0, v3dat[VLEN-1]}, 64'h1);
        check("data_e1", {32'd0, v3dat[1]}, 64'h0);
        a_data[0]      = 32'h1234_5678;
        a_data[VLEN-1] = 32'hFFFF_FFFF;
        step();
        check("data_hold_e0", {32'd0, v3dat[0]}, 64'hDEAD_BEEF);
        check("data_hold_e63", {32'd0, v3dat[VLEN-1]}, 64'h1);

        check("sb_empty", 64'(addr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
